// File: rtl/wb_addr_decoder_if.sv
// Wishbone bundle around wb_addr_decoder. Signal suffixes are as seen from the decoder.
// The decoder is the bus slave of the upstream master, so it takes the "slave" modport.
interface wb_addr_decoder_if #(
   parameter int NUM_SLAVES = 6,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]            m_wb_adr_i;
   logic [DATA_WIDTH-1:0]            m_wb_dat_i;
   logic [DATA_WIDTH-1:0]            m_wb_dat_o;
   logic                             m_wb_we_i;
   logic [DATA_WIDTH/8-1:0]          m_wb_sel_i;
   logic                             m_wb_stb_i;
   logic                             m_wb_cyc_i;
   logic                             m_wb_ack_o;
   logic                             m_wb_err_o;
   logic [ADDR_WIDTH-1:0]            s_wb_adr_o;
   logic [DATA_WIDTH-1:0]            s_wb_dat_o;
   logic                             s_wb_we_o;
   logic [DATA_WIDTH/8-1:0]          s_wb_sel_o;
   logic [NUM_SLAVES-1:0]            s_wb_stb_o;
   logic [NUM_SLAVES-1:0]            s_wb_ack_i;
   logic [NUM_SLAVES*DATA_WIDTH-1:0] s_wb_dat_i;

   modport slave (
      input  m_wb_adr_i, m_wb_dat_i, m_wb_we_i, m_wb_sel_i, m_wb_stb_i, m_wb_cyc_i,
      input  s_wb_ack_i, s_wb_dat_i,
      output m_wb_dat_o, m_wb_ack_o, m_wb_err_o,
      output s_wb_adr_o, s_wb_dat_o, s_wb_we_o, s_wb_sel_o, s_wb_stb_o
   );

   modport master (
      output m_wb_adr_i, m_wb_dat_i, m_wb_we_i, m_wb_sel_i, m_wb_stb_i, m_wb_cyc_i,
      output s_wb_ack_i, s_wb_dat_i,
      input  m_wb_dat_o, m_wb_ack_o, m_wb_err_o,
      input  s_wb_adr_o, s_wb_dat_o, s_wb_we_o, s_wb_sel_o, s_wb_stb_o
   );
endinterface

// File: rtl/wb_addr_decoder.sv
// 1-master / N-slave Wishbone decoder with a registered decode stage, unmapped and timeout bus errors.
// Define WB_DECODER_ERR_CAPTURE_EN to build the sticky error-capture registers (err_vld/adr/cause).
module wb_addr_decoder #(
   parameter int                                NUM_SLAVES     = 6,
   parameter int                                ADDR_WIDTH     = 32,
   parameter int                                DATA_WIDTH     = 32,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLAVE_BASE     = '0,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLAVE_MASK     = '0,
   parameter int                                TIMEOUT_CYCLES = 255
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_ni,
   wb_addr_decoder_if.slave      bus,
   input  logic                  err_clr_i,
   output logic                  err_vld_o,
   output logic [ADDR_WIDTH-1:0] err_adr_o,
   output logic                  err_cause_o
);
   localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_ERR} state_e;

   state_e                 state_q, state_d;
   logic [SEL_W-1:0]       sel_q, sel_d, hit_idx;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic                   hit_any, req, sel_ack, tmo_expire;
   logic [DATA_WIDTH-1:0]  sel_dat, dat_out;
   logic [NUM_SLAVES-1:0]  stb_out;
   logic                   ack_out, err_out;

   assign req        = bus.m_wb_cyc_i & bus.m_wb_stb_i;
   assign tmo_expire = (TIMEOUT_CYCLES != 0) && (int'(tmo_q) + 1 >= TIMEOUT_CYCLES);

   // Scanning downwards lets the lowest matching slave overwrite any higher one on overlap.
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
         if ((bus.m_wb_adr_i & SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
             SLAVE_BASE[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
            hit_any = 1'b1;
            hit_idx = SEL_W'(k);
         end
      end
   end

   always_comb begin
      sel_ack = 1'b0;
      sel_dat = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (sel_q == SEL_W'(k)) begin
            sel_ack = bus.s_wb_ack_i[k];
            sel_dat = bus.s_wb_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      tmo_d   = tmo_q;
      stb_out = '0;
      ack_out = 1'b0;
      err_out = 1'b0;
      dat_out = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (hit_any) begin
                  sel_d   = hit_idx;
                  tmo_d   = '0;
                  state_d = ST_ACTIVE;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_ACTIVE: begin
            for (int k = 0; k < NUM_SLAVES; k++) begin
               stb_out[k] = req && (sel_q == SEL_W'(k));
            end
            ack_out = bus.m_wb_cyc_i & sel_ack;
            dat_out = sel_dat;
            if (!bus.m_wb_cyc_i || sel_ack) begin
               state_d = ST_IDLE;
            end else begin
               if (int'(tmo_q) < TIMEOUT_CYCLES) tmo_d = tmo_q + 1'b1;
               if (tmo_expire) state_d = ST_ERR;
            end
         end
         ST_ERR: begin
            err_out = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.m_wb_dat_o = dat_out;
   assign bus.m_wb_ack_o = ack_out;
   assign bus.m_wb_err_o = err_out;
   assign bus.s_wb_stb_o = stb_out;
   assign bus.s_wb_adr_o = bus.m_wb_adr_i;
   assign bus.s_wb_dat_o = bus.m_wb_dat_i;
   assign bus.s_wb_we_o  = bus.m_wb_we_i;
   assign bus.s_wb_sel_o = bus.m_wb_sel_i;

`ifdef WB_DECODER_ERR_CAPTURE_EN
   // Sticky first-error capture; a clear on the same edge as a new error drops that error.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         err_vld_o   <= 1'b0;
         err_adr_o   <= '0;
         err_cause_o <= 1'b0;
      end else if (err_clr_i) begin
         err_vld_o   <= 1'b0;
      end else if (state_d == ST_ERR && !err_vld_o) begin
         err_vld_o   <= 1'b1;
         err_adr_o   <= bus.m_wb_adr_i;
         err_cause_o <= (state_q == ST_ACTIVE);
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr_i;
   assign err_vld_o      = 1'b0;
   assign err_adr_o      = '0;
   assign err_cause_o    = 1'b0;
`endif
endmodule

// File: tb/tb_wb_addr_decoder.sv
// Bench for wb_addr_decoder: directed scenarios plus a randomized run against a transaction-level model.
module tb_wb_addr_decoder;
   localparam int NS = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int T  = 4;
   localparam logic [NS*AW-1:0] BASE = {32'h0000_1000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
   localparam logic [NS*AW-1:0] MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hF000_0000, 32'hFFFF_0000};
`ifdef WB_DECODER_ERR_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          err_clr = 1'b0;
   logic          err_vld, err_cause;
   logic [AW-1:0] err_adr;

   int            checks = 0;
   int            failures = 0;

   // Slave models: slave k acks once its strobe has been held delay[k] cycles.
   int            delay [NS];
   int            scnt  [NS];
   logic [DW-1:0] sdata [NS];
   logic [NS-1:0] ack_raw;
   logic [NS-1:0] foreign_ack = '0;

   // Reference error-capture state.
   bit            m_vld = 1'b0;
   logic [AW-1:0] m_adr = '0;
   bit            m_cause = 1'b0;

   wb_addr_decoder_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   wb_addr_decoder #(
      .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(T)
   ) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(bus),
      .err_clr_i(err_clr), .err_vld_o(err_vld), .err_adr_o(err_adr), .err_cause_o(err_cause)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < NS; k++) begin
         ack_raw[k] = bus.s_wb_stb_o[k] && (scnt[k] >= delay[k]);
         bus.s_wb_dat_i[k*DW +: DW] = sdata[k];
      end
   end
   assign bus.s_wb_ack_i = ack_raw | foreign_ack;

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < NS; k++) begin
         if (!rst_n) scnt[k] <= 0;
         else scnt[k] <= (bus.s_wb_stb_o[k] && !ack_raw[k]) ? scnt[k] + 1 : 0;
      end
   end

   function automatic int ref_decode(input logic [AW-1:0] a);
      logic [AW-1:0] b, m;
      for (int k = 0; k < NS; k++) begin
         b = BASE[k*AW +: AW];
         m = MASK[k*AW +: AW];
         if ((a & m) == b) return k;
      end
      return -1;
   endfunction

   function automatic int pick_delay();
      int opts [6] = '{0, 1, 2, 3, 5, 1000};
      return opts[$urandom_range(0, 5)];
   endfunction

   // One transfer: cycle 1 is the decode cycle; the model predicts the ack/err cycle from the map and delays.
   task automatic xfer(input logic [AW-1:0] adr, input logic [NS-1:0] fack, input bit clr_entry);
      int k, done_n;
      bit is_ack;
      logic [NS-1:0] oh, exp_stb;
      logic [DW-1:0] wd;
      logic [DW/8-1:0] sl;
      logic we;
      k  = ref_decode(adr);
      oh = '0;
      if (k >= 0) oh[k] = 1'b1;
      if (k < 0) begin
         done_n = 2; is_ack = 1'b0;
      end else if (delay[k] <= T - 1) begin
         done_n = delay[k] + 2; is_ack = 1'b1;
      end else begin
         done_n = T + 2; is_ack = 1'b0;
      end
      wd = $urandom;
      sl = (DW/8)'($urandom);
      we = 1'($urandom);
      @(posedge clk); #1;
      for (int j = 0; j < NS; j++) sdata[j] = $urandom;
      bus.m_wb_adr_i = adr;
      bus.m_wb_dat_i = wd;
      bus.m_wb_we_i  = we;
      bus.m_wb_sel_i = sl;
      bus.m_wb_cyc_i = 1'b1;
      bus.m_wb_stb_i = 1'b1;
      foreign_ack    = fack & ~oh;
      err_clr        = clr_entry;
      for (int n = 1; n <= done_n; n++) begin
         if (n > 1) begin
            @(posedge clk); #1;
            err_clr = 1'b0;
         end
         @(negedge clk);
         exp_stb = (n >= 2 && (is_ack ? n <= done_n : n < done_n)) ? oh : '0;
         checks++;
         if (bus.s_wb_stb_o !== exp_stb) begin
            failures++;
            $display("FAIL stb adr=%h cycle=%0d: got %b want %b", adr, n, bus.s_wb_stb_o, exp_stb);
         end
         checks++;
         if (bus.m_wb_ack_o !== (is_ack && n == done_n)) begin
            failures++;
            $display("FAIL ack adr=%h cycle=%0d: got %b want %b", adr, n, bus.m_wb_ack_o, is_ack && n == done_n);
         end
         checks++;
         if (bus.m_wb_err_o !== (!is_ack && n == done_n)) begin
            failures++;
            $display("FAIL err adr=%h cycle=%0d: got %b want %b", adr, n, bus.m_wb_err_o, !is_ack && n == done_n);
         end
         if (is_ack && n == done_n) begin
            checks++;
            if (bus.m_wb_dat_o !== sdata[k]) begin
               failures++;
               $display("FAIL rdata adr=%h: got %h want %h", adr, bus.m_wb_dat_o, sdata[k]);
            end
         end
         if (n == 1) begin
            checks++;
            if ({bus.s_wb_adr_o, bus.s_wb_dat_o, bus.s_wb_we_o, bus.s_wb_sel_o} !== {adr, wd, we, sl}) begin
               failures++;
               $display("FAIL passthru: got %h/%h/%b/%h want %h/%h/%b/%h", bus.s_wb_adr_o, bus.s_wb_dat_o,
                        bus.s_wb_we_o, bus.s_wb_sel_o, adr, wd, we, sl);
            end
         end
      end
      if (clr_entry) m_vld = 1'b0;
      if (!is_ack && !(clr_entry && k < 0) && !m_vld) begin
         m_vld = 1'b1; m_adr = adr; m_cause = (k >= 0);
      end
      checks++;
      if (err_vld !== (CAP && m_vld)) begin
         failures++;
         $display("FAIL err_vld adr=%h: got %b want %b", adr, err_vld, CAP && m_vld);
      end
      if (!CAP || m_vld) begin
         checks++;
         if ({err_adr, err_cause} !== (CAP ? {m_adr, m_cause} : '0)) begin
            failures++;
            $display("FAIL err_capture: got %h/%b want %h/%b", err_adr, err_cause,
                     CAP ? m_adr : '0, CAP ? m_cause : 1'b0);
         end
      end
   endtask

   task automatic gap();
      @(posedge clk); #1;
      bus.m_wb_cyc_i = 1'b0;
      bus.m_wb_stb_i = 1'b0;
      foreign_ack    = '0;
      @(negedge clk);
      checks++;
      if ({bus.s_wb_stb_o, bus.m_wb_ack_o, bus.m_wb_err_o} !== '0) begin
         failures++;
         $display("FAIL idle: got stb=%b ack=%b err=%b want all 0", bus.s_wb_stb_o, bus.m_wb_ack_o, bus.m_wb_err_o);
      end
   endtask

   task automatic pulse_clear();
      @(posedge clk); #1;
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      m_vld   = 1'b0;
      @(negedge clk);
      checks++;
      if (err_vld !== 1'b0) begin
         failures++;
         $display("FAIL err_clear: got err_vld=%b want 0", err_vld);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({bus.s_wb_stb_o, bus.m_wb_ack_o, bus.m_wb_err_o, bus.m_wb_dat_o} !== '0) begin
         failures++;
         $display("FAIL reset_bus: got stb=%b ack=%b err=%b dat=%h want 0", bus.s_wb_stb_o, bus.m_wb_ack_o,
                  bus.m_wb_err_o, bus.m_wb_dat_o);
      end
      checks++;
      if ({err_vld, err_adr, err_cause} !== '0) begin
         failures++;
         $display("FAIL reset_capture: got %b/%h/%b want 0", err_vld, err_adr, err_cause);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic_read();
      for (int j = 0; j < NS; j++) delay[j] = 1;
      xfer(32'h0000_0010, '0, 1'b0);
      gap();
   endtask

   task automatic test_unmapped();
      xfer(32'h5000_0000, '0, 1'b0);
      gap();
   endtask

   task automatic test_timeout();
      pulse_clear();
      delay[1] = 1000;
      xfer(32'h1000_0040, '0, 1'b0);
      gap();
      delay[1] = 1;
   endtask

   task automatic test_overlap();
      xfer(32'h0000_1000, '0, 1'b0);
      gap();
   endtask

   task automatic test_abort_and_reset();
      delay[0] = 1000;
      @(posedge clk); #1;
      bus.m_wb_adr_i = 32'h0000_0040;
      bus.m_wb_cyc_i = 1'b1;
      bus.m_wb_stb_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.s_wb_stb_o !== 4'b0001) begin
         failures++;
         $display("FAIL abort_pre: got stb=%b want 0001", bus.s_wb_stb_o);
      end
      @(posedge clk); #1;
      bus.m_wb_cyc_i = 1'b0;
      bus.m_wb_stb_i = 1'b0;
      #1;
      checks++;
      if ({bus.s_wb_stb_o, bus.m_wb_ack_o, bus.m_wb_err_o} !== '0) begin
         failures++;
         $display("FAIL abort_drop: got stb=%b ack=%b err=%b want 0", bus.s_wb_stb_o, bus.m_wb_ack_o, bus.m_wb_err_o);
      end
      @(negedge clk);
      checks++;
      if ({bus.m_wb_ack_o, bus.m_wb_err_o} !== 2'b00) begin
         failures++;
         $display("FAIL abort_after: got ack=%b err=%b want 0", bus.m_wb_ack_o, bus.m_wb_err_o);
      end
      @(posedge clk); #1;
      bus.m_wb_cyc_i = 1'b1;
      bus.m_wb_stb_i = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.s_wb_stb_o !== 4'b0000) begin
         failures++;
         $display("FAIL abort_redecode: got stb=%b want 0000", bus.s_wb_stb_o);
      end
      @(negedge clk);
      checks++;
      if (bus.s_wb_stb_o !== 4'b0001) begin
         failures++;
         $display("FAIL abort_reactive: got stb=%b want 0001", bus.s_wb_stb_o);
      end
      #2 rst_n = 1'b0;
      #1;
      m_vld = 1'b0;
      checks++;
      if ({bus.s_wb_stb_o, bus.m_wb_ack_o, bus.m_wb_err_o, bus.m_wb_dat_o, err_vld} !== '0) begin
         failures++;
         $display("FAIL midreset: got stb=%b ack=%b err=%b dat=%h vld=%b want 0", bus.s_wb_stb_o,
                  bus.m_wb_ack_o, bus.m_wb_err_o, bus.m_wb_dat_o, err_vld);
      end
      @(posedge clk); #1;
      bus.m_wb_cyc_i = 1'b0;
      bus.m_wb_stb_i = 1'b0;
      rst_n = 1'b1;
      delay[0] = 1;
      gap();
   endtask

   task automatic test_clear_wins();
      pulse_clear();
      xfer(32'h5000_0000, '0, 1'b1);
      gap();
      xfer(32'h7000_0004, '0, 1'b0);
      gap();
   endtask

   task automatic test_ack_at_limit();
      delay[2] = T - 1;
      xfer(32'h2000_0ABC, '0, 1'b0);
      gap();
      pulse_clear();
      delay[2] = 1;
   endtask

   task automatic test_back_to_back();
      xfer(32'h0000_0020, '0, 1'b0);
      xfer(32'h1000_0004, '0, 1'b0);
      xfer(32'h6000_0000, '0, 1'b0);
      gap();
   endtask

   task automatic test_foreign_ack();
      delay[1] = 2;
      xfer(32'h1234_5678, '1, 1'b0);
      gap();
      delay[1] = 1;
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      bit b2b;
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 4))
            0: a = {16'h0000, 16'($urandom)};
            1: a = {4'h1, 28'($urandom)};
            2: a = {20'h20000, 12'($urandom)};
            3: a = {20'h00001, 12'($urandom)};
            default: a = $urandom;
         endcase
         xfer(a, NS'($urandom), 1'b0);
         b2b = ($urandom_range(0, 3) == 0);
         if (!b2b) begin
            gap();
            for (int j = 0; j < NS; j++) delay[j] = pick_delay();
            if ($urandom_range(0, 5) == 0) pulse_clear();
         end
      end
      gap();
   endtask

   initial begin
      bus.m_wb_adr_i = '0;
      bus.m_wb_dat_i = '0;
      bus.m_wb_we_i  = 1'b0;
      bus.m_wb_sel_i = '0;
      bus.m_wb_cyc_i = 1'b0;
      bus.m_wb_stb_i = 1'b0;
      for (int j = 0; j < NS; j++) begin
         delay[j] = 1;
         sdata[j] = '0;
      end
      test_reset();
      test_basic_read();
      test_unmapped();
      test_timeout();
      test_overlap();
      test_abort_and_reset();
      test_clear_wins();
      test_ack_at_limit();
      test_back_to_back();
      test_foreign_ack();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end
endmodule
